pc_sequencer: RTL and testbench

Sequential controller that owns the program counter and drives the 2-bit select of the 32-bit 4:1 next-PC multiplexer (`mux_4_1_32`). Each instruction is fetched from instruction memory over a req/ready handshake, and the block waits for the downstream control decision. It then drives the mux select and latches the mux output as the new PC. It sits between instruction fetch and the next-PC mux, and it also keeps a retired-instruction counter.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, next-PC mux select and retired count.
// Optional misaligned-PC trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] HALT_VEC  = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  input  logic        i_imem_ready,
  output logic        o_instr_valid,
  input  logic        i_ctrl_valid,
  input  logic        i_is_branch_taken,
  input  logic        i_is_jr,
  input  logic        i_is_halt,
  input  logic [31:0] i_next_pc,
  output logic [1:0]  o_pc_sel,
  output logic [31:0] o_pc,
  output logic [31:0] o_retired,
  output logic        o_halted,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [1:0]  r_pc_sel;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_instr_valid;
  logic        r_halted;
  logic [1:0]  w_sel_decision;
  logic [31:0] w_pc_load;

  // Halt outranks jump-register, which outranks a taken branch.
  always_comb begin
    w_sel_decision = 2'b00;
    if (i_is_halt)              w_sel_decision = 2'b11;
    else if (i_is_jr)           w_sel_decision = 2'b10;
    else if (i_is_branch_taken) w_sel_decision = 2'b01;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_fault;
  logic w_misaligned;
  assign w_misaligned = |i_next_pc[1:0];
  assign w_pc_load    = i_next_pc;
  assign o_fault      = r_fault;
`else
  assign w_pc_load    = {i_next_pc[31:2], 2'b00};
  assign o_fault      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_VEC;
      r_pc_sel      <= 2'b00;
      r_retired     <= 32'd0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      r_fault       <= 1'b0;
`endif
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        S_FETCH: begin
          if (i_imem_ready) begin
            r_state       <= S_EXEC;
            r_instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (i_ctrl_valid) begin
            r_pc_sel <= w_sel_decision;
            r_state  <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_pc      <= w_pc_load;
          r_retired <= r_retired + 32'd1;
          if (r_pc_sel == 2'b11) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
`ifdef PC_ALIGN_CHECK_EN
          else if (w_misaligned) begin
            r_fault  <= 1'b1;
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
`endif
          else begin
            r_state <= S_FETCH;
          end
        end
        S_HALT:  r_halted <= 1'b1;
        default: r_state  <= S_BOOT;
      endcase
    end
  end

  // The external mux must route the halt vector when select 11 is in force.
  a_halt_target: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_UPDATE && r_pc_sel == 2'b11) |-> (i_next_pc == HALT_VEC));

  assign o_imem_req    = (r_state == S_FETCH);
  assign o_instr_valid = r_instr_valid;
  assign o_pc_sel      = r_pc_sel;
  assign o_pc          = r_pc;
  assign o_retired     = r_retired;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner cases, random vs. reference model.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] HALT_VEC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_ready = 1'b0;
  logic        ctrl_valid = 1'b0;
  logic        is_br = 1'b0, is_jr = 1'b0, is_halt = 1'b0;
  logic [31:0] next_pc;
  logic        imem_req, instr_valid, halted, fault;
  logic [1:0]  pc_sel;
  logic [31:0] pc, retired;
  logic [31:0] a1 = 32'h0, a2 = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.RESET_VEC(RESET_VEC), .HALT_VEC(HALT_VEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(imem_req), .i_imem_ready(imem_ready), .o_instr_valid(instr_valid),
    .i_ctrl_valid(ctrl_valid), .i_is_branch_taken(is_br), .i_is_jr(is_jr), .i_is_halt(is_halt),
    .i_next_pc(next_pc), .o_pc_sel(pc_sel), .o_pc(pc), .o_retired(retired),
    .o_halted(halted), .o_fault(fault)
  );

  always #5 clk = ~clk;

  // External 4:1 next-PC mux.
  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_sel)
      2'b01:   next_pc = a1;
      2'b10:   next_pc = a2;
      2'b11:   next_pc = HALT_VEC;
      default: next_pc = pc + 32'd4;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with the DUT in FETCH.
  task automatic do_reset();
    #2;
    imem_ready = 0; ctrl_valid = 0; is_br = 0; is_jr = 0; is_halt = 0;
    rst_n = 0;
    #1;
    chk("rst_pc", pc, RESET_VEC);
    chk("rst_sel", {30'd0, pc_sel}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // One instruction: rw fetch stall cycles, cw decision stall cycles. Ends after the UPDATE edge.
  task automatic do_instr(input int rw, input int cw, input logic h, input logic j,
                          input logic b, input logic [31:0] v1, input logic [31:0] v2);
    logic [31:0] pc0;
    logic [1:0]  sel0;
    a1 = v1; a2 = v2;
    pc0 = pc; sel0 = pc_sel;
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    for (int k = 0; k < rw; k++) begin
      imem_ready = 0;
      ctrl_valid = 1'($urandom); is_halt = 1; is_jr = 1;
      tick();
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_pc", pc, pc0);
      chk("stall_ivalid", {31'd0, instr_valid}, 32'd0);
      chk("stall_sel", {30'd0, pc_sel}, {30'd0, sel0});
    end
    imem_ready = 1; ctrl_valid = 0; is_halt = 0; is_jr = 0;
    tick();
    imem_ready = 0;
    chk("exec_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    for (int k = 0; k < cw; k++) begin
      ctrl_valid = 0;
      is_halt = 1'($urandom); is_jr = 1'($urandom); is_br = 1'($urandom);
      tick();
      chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
      chk("wait_sel", {30'd0, pc_sel}, {30'd0, sel0});
    end
    ctrl_valid = 1; is_halt = h; is_jr = j; is_br = b;
    tick();
    ctrl_valid = 0; is_halt = 0; is_jr = 0; is_br = 0;
    tick();
  endtask

  typedef struct {
    logic        h, j, b;
    logic [31:0] v1, v2;
    logic [1:0]  exp_sel;
    logic [31:0] exp_pc;
    logic        exp_halted, exp_fault;
  } vec_t;

  vec_t vecs[6];

  // Reference: pick the target by select priority, then apply the alignment policy.
  task automatic model(input logic h, input logic j, input logic b, input logic [31:0] cur,
                       input logic [31:0] v1, input logic [31:0] v2, output logic [1:0] sel,
                       output logic [31:0] npc, output logic hlt, output logic flt);
    logic [31:0] tgt;
    if (h)      begin sel = 2'd3; tgt = HALT_VEC; end
    else if (j) begin sel = 2'd2; tgt = v2; end
    else if (b) begin sel = 2'd1; tgt = v1; end
    else        begin sel = 2'd0; tgt = cur + 4; end
`ifdef PC_ALIGN_CHECK_EN
    npc = tgt;
    flt = (tgt % 4) != 0;
`else
    npc = tgt - (tgt % 4);
    flt = 1'b0;
`endif
    hlt = h || flt;
  endtask

  initial begin
    logic [1:0]  e_sel;
    logic [31:0] e_pc, ref_pc, ref_ret, v1, v2;
    logic        e_h, e_f, h, j, b;

    vecs[0] = '{0, 0, 0, 32'h40, 32'h200, 2'd0, 32'h4, 0, 0};
    vecs[1] = '{0, 0, 1, 32'h40, 32'h200, 2'd1, 32'h40, 0, 0};
    vecs[2] = '{0, 1, 1, 32'h40, 32'h200, 2'd2, 32'h200, 0, 0};
    vecs[3] = '{1, 1, 1, 32'h40, 32'h200, 2'd3, 32'hFFFF_FFFC, 1, 0};
`ifdef PC_ALIGN_CHECK_EN
    vecs[4] = '{0, 1, 0, 32'h40, 32'h102, 2'd2, 32'h102, 1, 1};
`else
    vecs[4] = '{0, 1, 0, 32'h40, 32'h102, 2'd2, 32'h100, 0, 0};
`endif
    vecs[5] = '{0, 0, 1, 32'h1000_0000, 32'h8, 2'd1, 32'h1000_0000, 0, 0};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      do_instr(0, 0, vecs[i].h, vecs[i].j, vecs[i].b, vecs[i].v1, vecs[i].v2);
      $display("vec %0d: sel=%0d pc=%h halted=%0d fault=%0d", i, pc_sel, pc, halted, fault);
      chk("vec_sel", {30'd0, pc_sel}, {30'd0, vecs[i].exp_sel});
      chk("vec_pc", pc, vecs[i].exp_pc);
      chk("vec_retired", retired, 32'd1);
      chk("vec_halted", {31'd0, halted}, {31'd0, vecs[i].exp_halted});
      chk("vec_fault", {31'd0, fault}, {31'd0, vecs[i].exp_fault});
      chk("vec_req", {31'd0, imem_req}, {31'd0, ~vecs[i].exp_halted});
    end

    // Halt is absorbing even with ready/ctrl asserted.
    do_reset();
    do_instr(0, 1, 1, 1, 1, 32'h40, 32'h200);
    imem_ready = 1; ctrl_valid = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_pc", pc, HALT_VEC);
      chk("halt_retired", retired, 32'd1);
      chk("halt_flag", {31'd0, halted}, 32'd1);
    end
    $display("halt absorb: pc=%h retired=%0d", pc, retired);

    // Free-running sequence at the minimum instruction period.
    do_reset();
    imem_ready = 1; ctrl_valid = 1;
    chk("seq_pc0", pc, 32'h0);
    for (int e = 2; e <= 12; e++) begin
      tick();
      if (e == 4 || e == 7 || e == 10) begin
        chk("seq_req", {31'd0, imem_req}, 32'd1);
        chk("seq_pc", pc, 32'((e - 1) / 3 * 4));
      end
    end
    chk("seq_retired", retired, 32'd3);
    chk("seq_pc_end", pc, 32'hC);
    $display("sequence: pc=%h retired=%0d", pc, retired);
    imem_ready = 0; ctrl_valid = 0;

    // Fetch back-pressure.
    do_reset();
    do_instr(5, 2, 0, 0, 0, 32'h0, 32'h0);
    chk("bp_pc", pc, 32'h4);
    chk("bp_retired", retired, 32'd1);
    $display("backpressure: pc=%h retired=%0d", pc, retired);

    // Asynchronous reset in the middle of EXEC.
    do_reset();
    do_instr(0, 0, 0, 0, 1, 32'h40, 32'h0);
    chk("ar_pre_pc", pc, 32'h40);
    imem_ready = 1;
    tick();
    imem_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("ar_pc", pc, RESET_VEC);
    chk("ar_sel", {30'd0, pc_sel}, 32'd0);
    chk("ar_retired", retired, 32'd0);
    tick();
    rst_n = 1;
    chk("ar_boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("ar_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("ar_fetch_pc", pc, RESET_VEC);
    $display("async reset: pc=%h retired=%0d", pc, retired);

    // Randomised instructions against the reference model.
    do_reset();
    ref_pc = RESET_VEC; ref_ret = 0;
    for (int n = 0; n < 200; n++) begin
      h = ($urandom % 16) == 0;
      j = ($urandom % 3) == 0;
      b = 1'($urandom);
      v1 = $urandom & 32'hFFFF_FFFC;
      v2 = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 8 == 0) v1[1:0] = 2'($urandom);
      if ($urandom % 8 == 0) v2[1:0] = 2'($urandom);
      model(h, j, b, ref_pc, v1, v2, e_sel, e_pc, e_h, e_f);
      do_instr(int'($urandom % 3), int'($urandom % 3), h, j, b, v1, v2);
      ref_pc = e_pc; ref_ret = ref_ret + 1;
      $display("rand %0d: sel=%0d pc=%h retired=%0d halted=%0d", n, pc_sel, pc, retired, halted);
      chk("rnd_sel", {30'd0, pc_sel}, {30'd0, e_sel});
      chk("rnd_pc", pc, ref_pc);
      chk("rnd_retired", retired, ref_ret);
      chk("rnd_halted", {31'd0, halted}, {31'd0, e_h});
      chk("rnd_fault", {31'd0, fault}, {31'd0, e_f});
      if (e_h) begin
        do_reset();
        ref_pc = RESET_VEC; ref_ret = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
